// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes,
// ALUOp codes, operand/result mux encodings and the sequencer state type.
package rv_ctrl_pkg;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALUOp handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC     = 2'b00;
   localparam logic [1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [1:0] SRCA_RS1    = 2'b10;
   localparam logic [1:0] SRCA_ZERO   = 2'b11;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   typedef enum logic [3:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_UPPER,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_TRAP
   } state_t;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// muxes, enables and the memory request handshake.
module multicycle_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter bit TRAP_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             branch_cond,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic             illegal_instr,
   output logic [CNT_W-1:0] instret
);

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] instret_reg;
   logic             illegal_reg;
   logic             retire;

   // An instruction retires whenever control returns to FETCH from a
   // working state; waiting in FETCH and leaving START do not count.
   assign retire = (state_next == S_FETCH) && (state_reg != S_FETCH) &&
                   (state_reg != S_START);

   assign instret       = instret_reg;
   assign illegal_instr = illegal_reg;

   // State register, retired counter and sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_START;
         instret_reg <= '0;
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (retire)
            instret_reg <= instret_reg + CNT_W'(1);
         if (state_next == S_TRAP)
            illegal_reg <= 1'b1;
      end
   end

   // Next-state selection
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_START:  state_next = S_FETCH;
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR;
               OP_LUI, OP_AUIPC:  state_next = S_UPPER;
               default:           state_next = TRAP_EN ? S_TRAP : S_FETCH;
            endcase
         end
         S_MEMADR: state_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  if (mem_ready) state_next = S_FETCH;
         S_EXECR:  state_next = S_ALUWB;
         S_EXECI:  state_next = S_ALUWB;
         S_UPPER:  state_next = S_ALUWB;
         S_ALUWB:  state_next = S_FETCH;
         S_BRANCH: state_next = S_FETCH;
         S_JAL:    state_next = S_ALUWB;
         S_JALR:   state_next = S_JAL;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_START;
      endcase
   end

   // Output decode of the current state; enables in wait states only fire
   // with mem_ready, and BRANCH passes branch_cond straight to pc_write
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALUOUT;
      case (state_reg)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR, S_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_MEMDATA;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            adr_src = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_RTYPE;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ITYPE;
         end
         S_UPPER: begin
            // LUI adds the immediate to zero, AUIPC to the instruction's PC
            alu_src_a = (opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_BRANCH;
            pc_write  = branch_cond;
         end
         S_JAL: begin
            // PC takes the target held in ALUOut while the ALU forms oldPC+4
            pc_write  = 1'b1;
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed, table-driven bench for multicycle_control_fsm. One instance
// traps on illegal opcodes, a second one treats them as NOPs.
module tb_multicycle_control_fsm;

   // Expected control bundle:
   // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, a, b, op, rs}
   localparam logic [13:0] C_ZERO   = 14'b000000_00_00_00_00;
   localparam logic [13:0] C_FWAIT  = 14'b100000_00_10_00_10;
   localparam logic [13:0] C_FRDY   = 14'b100110_00_10_00_10;
   localparam logic [13:0] C_DEC    = 14'b000000_01_01_00_00;
   localparam logic [13:0] C_MEMADR = 14'b000000_10_01_00_00;
   localparam logic [13:0] C_MEMRD  = 14'b101000_00_00_00_00;
   localparam logic [13:0] C_MEMWB  = 14'b000001_00_00_00_01;
   localparam logic [13:0] C_MEMWR  = 14'b111000_00_00_00_00;
   localparam logic [13:0] C_EXECR  = 14'b000000_10_00_10_00;
   localparam logic [13:0] C_EXECI  = 14'b000000_10_01_11_00;
   localparam logic [13:0] C_LUI    = 14'b000000_11_01_00_00;
   localparam logic [13:0] C_AUIPC  = 14'b000000_01_01_00_00;
   localparam logic [13:0] C_ALUWB  = 14'b000001_00_00_00_00;
   localparam logic [13:0] C_BR_T   = 14'b000010_10_00_01_00;
   localparam logic [13:0] C_BR_N   = 14'b000000_10_00_01_00;
   localparam logic [13:0] C_JAL    = 14'b000010_01_10_00_00;
   localparam logic [13:0] C_JALR   = 14'b000000_10_01_00_00;

   typedef struct {
      string       name;
      logic [6:0]  opcode;
      logic        bc;
      logic        mr;
      logic [13:0] exp_ctrl;
      logic        exp_ill;
      int          exp_ret;
      logic [13:0] exp0_ctrl;
      logic        exp0_ill;
      int          exp0_ret;
   } vec_t;

   vec_t vecs[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        branch_cond;
   logic        mem_ready;

   logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic        illegal_instr;
   logic [31:0] instret;

   logic        mem_req0, mem_we0, adr_src0, ir_write0, pc_write0, reg_write0;
   logic [1:0]  alu_src_a0, alu_src_b0, alu_op0, result_src0;
   logic        illegal_instr0;
   logic [31:0] instret0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.CNT_W(32), .TRAP_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src),
      .illegal_instr(illegal_instr), .instret(instret)
   );

   multicycle_control_fsm #(.CNT_W(32), .TRAP_EN(1'b0)) u_dut_nop (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
      .mem_ready(mem_ready), .mem_req(mem_req0), .mem_we(mem_we0),
      .adr_src(adr_src0), .ir_write(ir_write0), .pc_write(pc_write0),
      .reg_write(reg_write0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
      .alu_op(alu_op0), .result_src(result_src0),
      .illegal_instr(illegal_instr0), .instret(instret0)
   );

   wire [13:0] ctrl  = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                        alu_src_a, alu_src_b, alu_op, result_src};
   wire [13:0] ctrl0 = {mem_req0, mem_we0, adr_src0, ir_write0, pc_write0,
                        reg_write0, alu_src_a0, alu_src_b0, alu_op0, result_src0};

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push2(input string nm, input logic [6:0] op, input logic bc,
                        input logic mr, input logic [13:0] ex, input logic il,
                        input int rt, input logic [13:0] ex0, input logic il0,
                        input int rt0);
      vec_t v;
      v.name = nm; v.opcode = op; v.bc = bc; v.mr = mr;
      v.exp_ctrl = ex; v.exp_ill = il; v.exp_ret = rt;
      v.exp0_ctrl = ex0; v.exp0_ill = il0; v.exp0_ret = rt0;
      vecs.push_back(v);
   endtask

   // Both instances behave identically on legal instructions
   task automatic push(input string nm, input logic [6:0] op, input logic bc,
                       input logic mr, input logic [13:0] ex, input int rt);
      push2(nm, op, bc, mr, ex, 1'b0, rt, ex, 1'b0, rt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- vector table ----------------
      push("start",        7'b0110011, 0, 1, C_ZERO,   0);
      push("add.fetch",    7'b0110011, 0, 1, C_FRDY,   0);
      push("add.decode",   7'b0110011, 0, 1, C_DEC,    0);
      push("add.execr",    7'b0110011, 0, 1, C_EXECR,  0);
      push("add.aluwb",    7'b0110011, 0, 1, C_ALUWB,  0);
      push("lw.fwait1",    7'b0000011, 0, 0, C_FWAIT,  1);
      push("lw.fwait2",    7'b0000011, 0, 0, C_FWAIT,  1);
      push("lw.fwait3",    7'b0000011, 0, 0, C_FWAIT,  1);
      push("lw.fetch",     7'b0000011, 0, 1, C_FRDY,   1);
      push("lw.decode",    7'b0000011, 0, 1, C_DEC,    1);
      push("lw.memadr",    7'b0000011, 0, 1, C_MEMADR, 1);
      push("lw.rdwait1",   7'b0000011, 0, 0, C_MEMRD,  1);
      push("lw.rdwait2",   7'b0000011, 0, 0, C_MEMRD,  1);
      push("lw.rdwait3",   7'b0000011, 0, 0, C_MEMRD,  1);
      push("lw.memrd",     7'b0000011, 0, 1, C_MEMRD,  1);
      push("lw.memwb",     7'b0000011, 0, 1, C_MEMWB,  1);
      push("sw.fetch",     7'b0100011, 0, 1, C_FRDY,   2);
      push("sw.decode",    7'b0100011, 0, 1, C_DEC,    2);
      push("sw.memadr",    7'b0100011, 0, 1, C_MEMADR, 2);
      push("sw.wrwait",    7'b0100011, 0, 0, C_MEMWR,  2);
      push("sw.memwr",     7'b0100011, 0, 1, C_MEMWR,  2);
      push("beqt.fetch",   7'b1100011, 1, 1, C_FRDY,   3);
      push("beqt.decode",  7'b1100011, 1, 1, C_DEC,    3);
      push("beqt.branch",  7'b1100011, 1, 1, C_BR_T,   3);
      push("beqn.fetch",   7'b1100011, 0, 1, C_FRDY,   4);
      push("beqn.decode",  7'b1100011, 0, 1, C_DEC,    4);
      push("beqn.branch",  7'b1100011, 0, 1, C_BR_N,   4);
      push("jalr.fetch",   7'b1100111, 0, 1, C_FRDY,   5);
      push("jalr.decode",  7'b1100111, 0, 1, C_DEC,    5);
      push("jalr.jalr",    7'b1100111, 0, 1, C_JALR,   5);
      push("jalr.jal",     7'b1100111, 0, 1, C_JAL,    5);
      push("jalr.aluwb",   7'b1100111, 0, 1, C_ALUWB,  5);
      push("jal.fetch",    7'b1101111, 0, 1, C_FRDY,   6);
      push("jal.decode",   7'b1101111, 0, 1, C_DEC,    6);
      push("jal.jal",      7'b1101111, 0, 1, C_JAL,    6);
      push("jal.aluwb",    7'b1101111, 0, 1, C_ALUWB,  6);
      push("addi.fetch",   7'b0010011, 0, 1, C_FRDY,   7);
      push("addi.decode",  7'b0010011, 0, 1, C_DEC,    7);
      push("addi.execi",   7'b0010011, 0, 1, C_EXECI,  7);
      push("addi.aluwb",   7'b0010011, 0, 1, C_ALUWB,  7);
      push("lui.fetch",    7'b0110111, 0, 1, C_FRDY,   8);
      push("lui.decode",   7'b0110111, 0, 1, C_DEC,    8);
      push("lui.upper",    7'b0110111, 0, 1, C_LUI,    8);
      push("lui.aluwb",    7'b0110111, 0, 1, C_ALUWB,  8);
      push("auipc.fetch",  7'b0010111, 0, 1, C_FRDY,   9);
      push("auipc.decode", 7'b0010111, 0, 1, C_DEC,    9);
      push("auipc.upper",  7'b0010111, 0, 1, C_AUIPC,  9);
      push("auipc.aluwb",  7'b0010111, 0, 1, C_ALUWB,  9);
      push("ill.fetch",    7'b1111111, 0, 1, C_FRDY,  10);
      push("ill.decode",   7'b1111111, 0, 1, C_DEC,   10);
      push2("trap1", 7'b1111111, 0, 1, C_ZERO, 1, 10, C_FRDY,  0, 11);
      push2("trap2", 7'b1111111, 0, 1, C_ZERO, 1, 10, C_DEC,   0, 11);
      push2("trap3", 7'b1111111, 0, 0, C_ZERO, 1, 10, C_FWAIT, 0, 12);
      push2("trap4", 7'b1111111, 0, 1, C_ZERO, 1, 10, C_FRDY,  0, 12);
      push2("trap5", 7'b1111111, 0, 1, C_ZERO, 1, 10, C_DEC,   0, 12);

      // ---------------- reset ----------------
      rst_n = 1'b0; opcode = 7'b0110011; branch_cond = 1'b0; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst.ctrl",    {18'd0, ctrl},          32'd0);
      check("rst.ill",     {31'd0, illegal_instr}, 32'd0);
      check("rst.instret", instret,                32'd0);
      $display("reset held 3 cycles: ctrl=%b instret=%0d", ctrl, instret);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         opcode      = vecs[i].opcode;
         branch_cond = vecs[i].bc;
         mem_ready   = vecs[i].mr;
         #1;
         check({vecs[i].name, ".ctrl"},  {18'd0, ctrl},  {18'd0, vecs[i].exp_ctrl});
         check({vecs[i].name, ".ill"},   {31'd0, illegal_instr}, {31'd0, vecs[i].exp_ill});
         check({vecs[i].name, ".ret"},   instret, vecs[i].exp_ret);
         check({vecs[i].name, ".ctrl0"}, {18'd0, ctrl0}, {18'd0, vecs[i].exp0_ctrl});
         check({vecs[i].name, ".ill0"},  {31'd0, illegal_instr0}, {31'd0, vecs[i].exp0_ill});
         check({vecs[i].name, ".ret0"},  instret0, vecs[i].exp0_ret);
         $display("vec %0d %s: ctrl=%b ill=%b ret=%0d | nop ctrl=%b ret=%0d",
                  i, vecs[i].name, ctrl, illegal_instr, instret, ctrl0, instret0);
         @(negedge clk);
      end

      // ---------------- async reset out of TRAP and mid-fetch ----------------
      rst_n = 1'b0;
      #1;
      check("trap_rst.ill",     {31'd0, illegal_instr}, 32'd0);
      check("trap_rst.instret", instret,                32'd0);
      check("trap_rst.ctrl",    {18'd0, ctrl},          32'd0);
      $display("reset from trap: ill=%b instret=%0d", illegal_instr, instret);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b0;
      #1;
      check("rst2.start", {18'd0, ctrl}, 32'd0);
      @(negedge clk);
      #1;
      check("midreq.fetch", {18'd0, ctrl}, {18'd0, C_FWAIT});
      #2;
      rst_n = 1'b0;
      #1;
      check("midreq.mem_req",  {31'd0, mem_req},  32'd0);
      check("midreq.mem_req0", {31'd0, mem_req0}, 32'd0);
      check("midreq.ctrl",     {18'd0, ctrl},     32'd0);
      $display("reset mid-fetch: mem_req=%b mem_req0=%b", mem_req, mem_req0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
